// File: rtl/rtc_bus_pkg.sv
// Shared types and default timing for the RTC multiplexed-bus sequencer.
// Holds the state encoding, the read/write flag values and the state successor function.
package rtc_bus_pkg;

  localparam int SETUP_DEF = 2;
  localparam int PULSE_DEF = 10;
  localparam int HOLD_DEF  = 2;
  localparam int GAP_DEF   = 4;
  localparam int CW_DEF    = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_HOLD   = 4'd3,
    ST_GAP      = 4'd4,
    ST_D_SETUP  = 4'd5,
    ST_D_STROBE = 4'd6,
    ST_D_HOLD   = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

  // Successor once the current timed state has run out; IDLE is left only by start.
  function automatic state_e next_state(input state_e s);
    case (s)
      ST_A_SETUP:  return ST_A_STROBE;
      ST_A_STROBE: return ST_A_HOLD;
      ST_A_HOLD:   return ST_GAP;
      ST_GAP:      return ST_D_SETUP;
      ST_D_SETUP:  return ST_D_STROBE;
      ST_D_STROBE: return ST_D_HOLD;
      ST_D_HOLD:   return ST_DONE;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request and pad-side signals of the RTC bus sequencer.
// master = upstream register logic plus pad input; slave = the sequencer.
interface rtc_bus_sequencer_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       en_tri_e;
  logic       en_tri_l;
  logic       cs_n;
  logic       ad;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] rdata;
  logic       busy;
  logic       done;

  modport master (
    output start, rw, addr, wdata, bus_in,
    input  bus_out, en_tri_e, en_tri_l, cs_n, ad, wr_n, rd_n, rdata, busy, done
  );

  modport slave (
    input  start, rw, addr, wdata, bus_in,
    output bus_out, en_tri_e, en_tri_l, cs_n, ad, wr_n, rd_n, rdata, busy, done
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times each bus-cycle state.
// expired is high while the count is zero; the count then rests at zero.
module rtc_phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences one RTC read or write as address phase, gap and data phase on the shared bus.
// Every output is a flop loaded from the next-state decode, so cs_n and the strobes cannot glitch.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int SETUP = SETUP_DEF,
  parameter int PULSE = PULSE_DEF,
  parameter int HOLD  = HOLD_DEF,
  parameter int GAP   = GAP_DEF,
  parameter int CW    = CW_DEF
) (
  input logic                clk,
  input logic                reset_n,
  rtc_bus_sequencer_if.slave bus
);

  localparam longint TMAX = (64'd1 << CW) - 64'd1;

  generate
    if (CW < 1 || CW > 31 ||
        SETUP < 1 || SETUP > TMAX || PULSE < 1 || PULSE > TMAX ||
        HOLD  < 1 || HOLD  > TMAX || GAP   < 1 || GAP   > TMAX) begin : g_bad_timing
      $error("rtc_bus_sequencer: timing parameter outside 1 .. 2**CW-1");
    end
  endgenerate

  localparam logic [CW-1:0] SETUP_M1 = CW'(SETUP - 1);
  localparam logic [CW-1:0] PULSE_M1 = CW'(PULSE - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_M1   = CW'(GAP - 1);

  function automatic logic [CW-1:0] reload_val(input state_e s);
    case (s)
      ST_A_SETUP, ST_D_SETUP:   return SETUP_M1;
      ST_A_STROBE, ST_D_STROBE: return PULSE_M1;
      ST_A_HOLD, ST_D_HOLD:     return HOLD_M1;
      ST_GAP:                   return GAP_M1;
      default:                  return '0;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic          timer_load, expired;
  logic [CW-1:0] timer_val;
  logic          accept;

  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;

  logic       cs_n_q, cs_n_d, ad_q, ad_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic       en_e_q, en_e_d, en_l_q, en_l_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] bus_out_q, bus_out_d, rdata_q, rdata_d;

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (state_q == ST_IDLE) begin
      accept = bus.start;
      if (bus.start) state_d = ST_A_SETUP;
    end else if (expired) begin
      state_d = next_state(state_q);
    end
    // Every state change except the return to IDLE starts a new timed interval.
    timer_load = (state_d != state_q) && (state_d != ST_IDLE);
    timer_val  = reload_val(state_d);

    rw_d    = accept ? bus.rw    : rw_q;
    addr_d  = accept ? bus.addr  : addr_q;
    wdata_d = accept ? bus.wdata : wdata_q;
  end

  always_comb begin
    cs_n_d    = 1'b1;
    ad_d      = 1'b1;
    wr_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    en_e_d    = 1'b0;
    en_l_d    = 1'b0;
    bus_out_d = bus_out_q;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    rdata_d   = rdata_q;

    case (state_d)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        cs_n_d    = 1'b0;
        ad_d      = 1'b0;
        bus_out_d = addr_d;
        wr_n_d    = (state_d != ST_A_STROBE);
        en_e_d    = (rw_d == RW_WRITE);
        en_l_d    = (rw_d == RW_READ);
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        cs_n_d = 1'b0;
        if (rw_d == RW_READ) begin
          bus_out_d = 8'h00;
          rd_n_d    = (state_d != ST_D_STROBE);
        end else begin
          bus_out_d = wdata_d;
          en_e_d    = 1'b1;
          wr_n_d    = (state_d != ST_D_STROBE);
        end
      end
      default: ;
    endcase

    // Capture on the final strobe cycle, just before rd_n rises.
    if (state_q == ST_D_STROBE && expired && rw_q == RW_READ) begin
      rdata_d = bus.bus_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rw_q      <= RW_WRITE;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      cs_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      en_e_q    <= 1'b0;
      en_l_q    <= 1'b0;
      bus_out_q <= 8'h00;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cs_n_q    <= cs_n_d;
      ad_q      <= ad_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      en_e_q    <= en_e_d;
      en_l_q    <= en_l_d;
      bus_out_q <= bus_out_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.ad       = ad_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.en_tri_e = en_e_q;
  assign bus.en_tri_l = en_l_q;
  assign bus.bus_out  = bus_out_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: default timing (dut0) and minimum timing (dut1).
// Expected per-cycle outputs come from a phase timeline computed from the durations.
module tb_rtc_bus_sequencer;
  import rtc_bus_pkg::*;

  localparam int S0 = 2, P0 = 10, H0 = 2, G0 = 4;
  localparam int S1 = 1, P1 = 1,  H1 = 1, G1 = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, bus_in = 8'h00;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_sequencer_if if0 ();
  rtc_bus_sequencer_if if1 ();

  assign if0.start  = start & ~sel;
  assign if1.start  = start & sel;
  assign if0.rw     = rw;
  assign if1.rw     = rw;
  assign if0.addr   = addr;
  assign if1.addr   = addr;
  assign if0.wdata  = wdata;
  assign if1.wdata  = wdata;
  assign if0.bus_in = bus_in;
  assign if1.bus_in = bus_in;

  rtc_bus_sequencer #(.SETUP(S0), .PULSE(P0), .HOLD(H0), .GAP(G0), .CW(8)) dut0 (
    .clk (clk), .reset_n (reset_n), .bus (if0)
  );
  rtc_bus_sequencer #(.SETUP(S1), .PULSE(P1), .HOLD(H1), .GAP(G1), .CW(8)) dut1 (
    .clk (clk), .reset_n (reset_n), .bus (if1)
  );

  logic       o_cs_n, o_ad, o_wr_n, o_rd_n, o_en_e, o_en_l, o_busy, o_done;
  logic [7:0] o_bus_out, o_rdata;

  assign o_cs_n    = sel ? if1.cs_n     : if0.cs_n;
  assign o_ad      = sel ? if1.ad       : if0.ad;
  assign o_wr_n    = sel ? if1.wr_n     : if0.wr_n;
  assign o_rd_n    = sel ? if1.rd_n     : if0.rd_n;
  assign o_en_e    = sel ? if1.en_tri_e : if0.en_tri_e;
  assign o_en_l    = sel ? if1.en_tri_l : if0.en_tri_l;
  assign o_busy    = sel ? if1.busy     : if0.busy;
  assign o_done    = sel ? if1.done     : if0.done;
  assign o_bus_out = sel ? if1.bus_out  : if0.bus_out;
  assign o_rdata   = sel ? if1.rdata    : if0.rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] last_rdata [2];
  logic [7:0] last_bus   [2];

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[k=%0d]: observed %02h expected %02h", tag, k, obs, exp);
    end
  endtask

  // Outputs of an idle sequencer: bus_out and rdata hold their last values.
  task automatic check_idle(input string tag, input int k);
    check({tag, ".cs_n"},    k, {7'd0, o_cs_n}, 8'd1);
    check({tag, ".ad"},      k, {7'd0, o_ad},   8'd1);
    check({tag, ".wr_n"},    k, {7'd0, o_wr_n}, 8'd1);
    check({tag, ".rd_n"},    k, {7'd0, o_rd_n}, 8'd1);
    check({tag, ".en_e"},    k, {7'd0, o_en_e}, 8'd0);
    check({tag, ".en_l"},    k, {7'd0, o_en_l}, 8'd0);
    check({tag, ".busy"},    k, {7'd0, o_busy}, 8'd0);
    check({tag, ".done"},    k, {7'd0, o_done}, 8'd0);
    check({tag, ".bus_out"}, k, o_bus_out, last_bus[sel]);
    check({tag, ".rdata"},   k, o_rdata,   last_rdata[sel]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle("idle", i);
      @(posedge clk); #1;
    end
  endtask

  // Called at posedge+1. Drives start for one cycle, then checks every busy cycle
  // against the timeline. glitch_k re-pulses start while busy; abort_k asserts reset.
  task automatic run_txn(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                         input logic [7:0] t_rdval, input int glitch_k, input int abort_k);
    int s, p, h, g, n, a_end, g_end, d_str, d_end, cap_k;
    logic in_a, in_g, in_d, a_strb, d_strb;
    logic [7:0] e_bus, e_rdata;
    s = sel ? S1 : S0;  p = sel ? P1 : P0;
    h = sel ? H1 : H0;  g = sel ? G1 : G0;
    n     = 2 * (s + p + h) + g + 1;
    a_end = s + p + h;
    g_end = a_end + g;
    d_str = g_end + s;
    cap_k = d_str + p - 1;
    d_end = g_end + s + p + h;

    start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
    @(negedge clk);
    check_idle("accept", -1);
    @(posedge clk); #1;
    start = 1'b0;

    for (int k = 0; k < n; k++) begin
      rw = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      start  = (k == glitch_k);
      bus_in = (k == cap_k) ? t_rdval : ~t_rdval;
      if (k == abort_k) begin
        #2 reset_n = 1'b0;
        #1;
        start = 1'b0;
        last_rdata[0] = 8'h00; last_rdata[1] = 8'h00;
        last_bus[0]   = 8'h00; last_bus[1]   = 8'h00;
        check_idle("abort", k);
        return;
      end
      @(negedge clk);
      in_a   = (k < a_end);
      in_g   = (k >= a_end) && (k < g_end);
      in_d   = (k >= g_end) && (k < d_end);
      a_strb = (k >= s) && (k < s + p);
      d_strb = (k >= d_str) && (k < d_str + p);
      e_bus   = (in_a || in_g) ? t_addr : (t_rw ? 8'h00 : t_wdata);
      e_rdata = (t_rw && k > cap_k) ? t_rdval : last_rdata[sel];
      check("cs_n",    k, {7'd0, o_cs_n}, {7'd0, !(in_a || in_d)});
      check("ad",      k, {7'd0, o_ad},   {7'd0, !in_a});
      check("wr_n",    k, {7'd0, o_wr_n}, {7'd0, !(a_strb || (d_strb && !t_rw))});
      check("rd_n",    k, {7'd0, o_rd_n}, {7'd0, !(d_strb && t_rw)});
      check("en_e",    k, {7'd0, o_en_e}, {7'd0, !t_rw && (in_a || in_d)});
      check("en_l",    k, {7'd0, o_en_l}, {7'd0, t_rw && in_a});
      check("busy",    k, {7'd0, o_busy}, 8'd1);
      check("done",    k, {7'd0, o_done}, {7'd0, k == n - 1});
      check("bus_out", k, o_bus_out, e_bus);
      check("rdata",   k, o_rdata,   e_rdata);
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (t_rw) last_rdata[sel] = t_rdval;
    last_bus[sel] = t_rw ? 8'h00 : t_wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    last_rdata[0] = 8'h00; last_rdata[1] = 8'h00;
    last_bus[0]   = 8'h00; last_bus[1]   = 8'h00;

    // Reset values, with start held high to show it has no effect in reset.
    start = 1'b1;
    @(negedge clk);
    check_idle("reset", 0);
    sel = 1'b1;
    check_idle("reset1", 0);
    sel = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // Directed write then read on default timing.
    run_txn(RW_WRITE, 8'h21, 8'h5A, 8'h00, -1, -1);
    idle(1);
    run_txn(RW_READ, 8'h22, 8'h00, 8'hC3, -1, -1);
    idle(2);

    // start re-pulsed while busy is ignored; the next transaction is clean.
    run_txn(RW_WRITE, 8'h30, 8'hA5, 8'h00, 4, -1);
    idle(1);
    run_txn(RW_WRITE, 8'h31, 8'h3C, 8'h00, -1, -1);

    // Back-to-back: next start in the cycle right after DONE.
    run_txn(RW_READ,  8'h05, 8'h00, 8'h96, -1, -1);
    run_txn(RW_WRITE, 8'h06, 8'h69, 8'h00, -1, -1);
    idle(1);

    // Reset during D_STROBE of a read, then a normal write.
    run_txn(RW_READ, 8'h22, 8'h00, 8'hE7, -1, 2 * S0 + P0 + 2 * H0 + G0 + S0 + 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(3);
    run_txn(RW_WRITE, 8'h44, 8'h12, 8'h00, -1, -1);
    idle(1);

    // Minimum timing: busy lasts 8 cycles, each strobe one cycle.
    sel = 1'b1;
    idle(1);
    run_txn(RW_READ,  8'h0D, 8'h00, 8'h7E, -1, -1);
    run_txn(RW_WRITE, 8'h0E, 8'hB4, 8'h00, -1, -1);
    run_txn(RW_READ,  8'h0F, 8'h00, 8'h81, 3, -1);
    idle(1);

    // Randomized transactions on either instance.
    for (int i = 0; i < 8; i++) begin
      sel = 1'($urandom);
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
